mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single memory port of the RISC-V core between the instruction-fetch requester (IF) and the load/store requester (LS). It arbitrates requests, holds the winning request stable on the memory bus until the memory acknowledges it, and returns the completion and read data to the owner. It also drives the select line of the core's 2-input address/data mux; select 0 means IF and select 1 means LS.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STREAK_MAX, 4, max consecutive LS grants while IF is pending before IF is forced to win (>=1)

Ports:
CLK  in  1  clock; all state on rising edge
RESET  in  1  synchronous, active-high reset
if_req  in  1  fetch request (read only)
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch completed; rdata valid
ls_req  in  1  load/store request
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_be  in  4  byte enables
ls_gnt  out  1  load/store request accepted this cycle
ls_rvalid  out  1  load/store completed
rdata  out  DATA_W  shared read data, qualified by if_rvalid/ls_rvalid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_ack  in  1  memory done; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data
sel  out  1  mux control: 0 = IF owner, 1 = LS owner

Behaviour:
- Reset: one clock and one synchronous active-high reset, named CLK and RESET. While RESET=1 at a rising edge:
  - state goes to IDLE.
  - Every output is 0 in the following cycle (mem_*, sel, rdata, gnt/rvalid).
  - streak goes to 0.
- Reset mid-transaction: RESET aborts the transaction. No rvalid is ever produced for it, and mem_req drops in the next cycle.
- FSM IDLE:
  - if_gnt and ls_gnt are combinational and asserted only in IDLE, for the winner only.
  - When a grant is issued, at the edge: state becomes BUSY; owner, sel and mem_addr/we/wdata/be are registered from the winner; mem_req becomes 1.
  - For an IF winner, mem_we and mem_be are driven as 0 and 4'hF.
  - The requester may change or drop its inputs after its gnt cycle.
- FSM BUSY:
  - gnt outputs are 0.
  - mem_req and all mem_* fields are held stable until mem_ack=1 is sampled.
  - At that edge: state returns to IDLE, and the owner's rvalid pulses high for exactly one cycle.
  - rdata is updated with mem_rdata only for reads. On stores rdata holds its previous value.
- Arbitration, evaluated in IDLE:
  - If only one requester is active, it wins.
  - If both are active, LS wins unless streak == STREAK_MAX, in which case IF wins.
- Streak counter:
  - LS grant while if_req=1: streak increments, saturating at STREAK_MAX.
  - LS grant while if_req=0: streak clears to 0.
  - Any IF grant: streak clears to 0.
- sel: equals the registered owner and holds its last value while IDLE.
- Throughput: at most one transaction every 2 cycles (grant cycle plus at least one BUSY cycle). No grant is issued in the cycle mem_ack is seen.
- mem_ack while IDLE: ignored; no state change and no rvalid.
- if_rvalid and ls_rvalid are never high together.

Test Plan:
1. IF read: if_req=1, if_addr=0x100 in cycle 0; mem_ack=1 with mem_rdata=0xDEADBEEF in cycle 1.
   - Required: if_gnt=1 in cycle 0; mem_req=1, mem_addr=0x100, sel=0 in cycle 1; if_rvalid=1 with rdata=0xDEADBEEF in cycle 2; mem_req=0 in cycle 2.
2. Store: ls_req=1, ls_we=1, ls_addr=0x2000, ls_wdata=0x12345678, ls_be=4'b0011; ack delayed 3 cycles.
   - Required: ls_gnt=1; sel=1; mem_we=1 and mem_be=0011, held stable for 3 BUSY cycles; single ls_rvalid pulse; rdata unchanged.
3. Contention: if_req and ls_req both held high; mem_ack=1 every BUSY cycle; STREAK_MAX=4.
   - Required grant order: LS, LS, LS, LS, IF, LS, LS, LS, LS, IF, …
4. Streak clear: LS, LS granted with if_req=1; then one LS grant with if_req=0; then both requesting.
   - Required: streak back to 0, so the next 4 contended grants go to LS.
5. Reset in BUSY: RESET=1 for one edge while mem_req=1.
   - Required: mem_req=0, sel=0, no rvalid next cycle. A following if_req completes normally.
6. Spurious ack: mem_ack=1 with no request pending.
   - Required: no rvalid, state stays IDLE, and the next request arbitrates normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (IF)
// and load/store (LS). Holds the winning request on the bus until mem_ack,
// then returns completion and read data to the owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_be,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel
);

    localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STREAK_MAX);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                sel_q, sel_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic                if_win, ls_win;

    // Arbitration: LS has priority unless IF has been starved for STREAK_MAX grants.
    always_comb begin
        if_win = if_req & (~ls_req | (streak_q == StreakMax));
        ls_win = ls_req & ~if_win;
        if_gnt = (state_q == StIdle) & if_win;
        ls_gnt = (state_q == StIdle) & ls_win;
    end

    // Next-state: capture the winner on grant, complete on mem_ack.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rdata_d     = rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (if_gnt) begin
                    state_d     = StBusy;
                    mem_req_d   = 1'b1;
                    sel_d       = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    streak_d    = '0;
                end else if (ls_gnt) begin
                    state_d     = StBusy;
                    mem_req_d   = 1'b1;
                    sel_d       = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_be_d    = ls_be;
                    // Only grants that actually passed over a waiting IF count.
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    if (sel_q) begin
                        ls_rvalid_d = 1'b1;
                    end else begin
                        if_rvalid_d = 1'b1;
                    end
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset clearing every registered output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            rdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rdata_q     <= rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
        end
    end

    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign rdata     = rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;

endmodule
